memory_controller: RTL and testbench
====================================

# memory_controller

Two-channel word-addressed memory controller that sits directly downstream of the hart's Load/Store/Fetch units. It accepts requests on a hart-to-memory-controller valid/ready channel, arbitrates round-robin between two requesters, and performs one access at a time against an internal single-port synchronous RAM. It returns exactly one response (read data or error) per accepted request on the memory-controller-to-hart channel of the requesting port.

## Interface
- CAPACITY_WORDS, 4096: RAM depth in 32-bit words. Valid byte addresses are 0 .. 4*CAPACITY_WORDS-1. Must be a power of two.
- clock  in  1  single clock; all state updates on rising edge.
- clear  in  1  reset, synchronous, active-high.
- chN$hart_to_memory_controller_valid  in  1  request valid (N = 0, 1).
- chN$hart_to_memory_controller_ready  out  1  request accepted when valid & ready.
- chN$hart_to_memory_controller_address  in  32  byte address.
- chN$hart_to_memory_controller_write  in  1  1 = write, 0 = read.
- chN$hart_to_memory_controller_write_data  in  32  full-word write data.
- chN$memory_controller_to_hart_valid  out  1  response valid.
- chN$memory_controller_to_hart_ready  in  1  requester accepts response.
- chN$memory_controller_to_hart_error  out  1  request was rejected.
- chN$memory_controller_to_hart_read_data  out  32  read word; 0 for writes and errors.

## Operation
- States: IDLE, ACCESS, RESPOND.
- Grant (combinational, IDLE only):
  - only one channel valid: that channel.
  - both channels valid: the channel other than last_grant.
  - none valid: the channel other than last_grant.
- Ready: chN ready = (state == IDLE) & (grant == N).
- Accept (IDLE, valid & ready on the granted channel):
  - capture channel, write flag and error flag.
  - error = address[1:0] != 0 OR address >= 4*CAPACITY_WORDS.
  - last_grant <= channel; next state ACCESS.
- RAM is driven on the accept cycle, word index address[log2(CAPACITY_WORDS)+1:2].
  - Non-error write: RAM written with write_data in that cycle.
  - Reads, and any error request: RAM not written.
- ACCESS: resp_data <= RAM output if (read & !error), else 0. Next state RESPOND.
- RESPOND:
  - captured channel's response valid = 1, error = captured error, read_data = resp_data.
  - All three held stable until that channel's response ready = 1, then next state IDLE.
  - The other channel's response outputs stay 0.
- Write responses: valid with read_data 0. Errors: read_data 0, error 1.
- Requests never update the RAM once rejected; no partial-word writes. Byte/half extraction is the Load unit's job.

## Timing
- Reset values: state IDLE, last_grant = 1, resp_data 0.
  - All response valid/error/read_data = 0.
  - ch0 ready = 1, ch1 ready = 0 (no requests pending).
- RAM contents are not cleared by reset.
- Latency: request accepted at cycle T; response valid at T+2 at the earliest.
  - Response handshake at T+2 frees IDLE at T+3, so the minimum issue interval is 3 cycles per request.
- Read-after-write: a read accepted after a write's response completes returns the written data.
- Back-to-back simultaneous requests alternate 0,1,0,1 while both are held valid.
- No request is accepted outside IDLE; ready is 0 in ACCESS and RESPOND.
- Response ready asserted in IDLE or ACCESS has no effect.
- Reset mid-operation (ACCESS or RESPOND) discards the pending response and returns to IDLE next cycle. A write accepted before reset stays committed.
- Addresses wrap never: anything at or above capacity is an error, with no aliasing.

## Test plan
- Write/read: ch0 write 0x100 <- 0xDEADBEEF, then ch0 read 0x100.
  - Expect the write response (error 0, data 0) at T+2.
  - Expect the read response data 0xDEADBEEF at T+2 of the read.
- Arbitration: ch0 and ch1 both valid reading 0x0 and 0x4 continuously after reset.
  - Grants go ch0 first, then ch1, then ch0.
  - Each response appears only on the granted channel.
- Unaligned: ch1 read at 0x102.
  - Expect error = 1, read_data 0.
  - A subsequent read of 0x100 returns unchanged memory.
- Out of range (CAPACITY_WORDS = 4096): write 0x4000 <- 0x12345678.
  - Expect error = 1.
  - Read 0x0 returns its prior value (no alias write).
- Backpressure: read 0x100 with response ready held 0 for 4 cycles.
  - valid/data stay at 0xDEADBEEF throughout.
  - ch0/ch1 request ready stays 0 until the handshake; IDLE resumes the cycle after ready = 1.
- Reset mid-RESPOND: assert clear while the response is valid.
  - Next cycle all response valids are 0 and ch0 ready = 1.
  - Data written earlier is still readable.

Source files
------------

// File: rtl/memory_controller_if.sv
// ============================================================================
// memory_controller_if
// One hart-side request/response channel of the memory controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface memory_controller_if;
  logic        hart_to_memory_controller_valid;
  logic        hart_to_memory_controller_ready;
  logic [31:0] hart_to_memory_controller_address;
  logic        hart_to_memory_controller_write;
  logic [31:0] hart_to_memory_controller_write_data;
  logic        memory_controller_to_hart_valid;
  logic        memory_controller_to_hart_ready;
  logic        memory_controller_to_hart_error;
  logic [31:0] memory_controller_to_hart_read_data;

  modport master (
    output hart_to_memory_controller_valid,
    input  hart_to_memory_controller_ready,
    output hart_to_memory_controller_address,
    output hart_to_memory_controller_write,
    output hart_to_memory_controller_write_data,
    input  memory_controller_to_hart_valid,
    output memory_controller_to_hart_ready,
    input  memory_controller_to_hart_error,
    input  memory_controller_to_hart_read_data
  );

  modport slave (
    input  hart_to_memory_controller_valid,
    output hart_to_memory_controller_ready,
    input  hart_to_memory_controller_address,
    input  hart_to_memory_controller_write,
    input  hart_to_memory_controller_write_data,
    output memory_controller_to_hart_valid,
    input  memory_controller_to_hart_ready,
    output memory_controller_to_hart_error,
    output memory_controller_to_hart_read_data
  );
endinterface

`default_nettype wire

// File: rtl/memory_controller.sv
// ============================================================================
// memory_controller
// Two-channel round-robin word memory controller over a single-port sync RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_controller #(
  parameter int CAPACITY_WORDS = 4096
) (
  input  logic               clock,
  input  logic               clear,
  memory_controller_if.slave ch0,
  memory_controller_if.slave ch1
);

  localparam int          c_aw    = $clog2(CAPACITY_WORDS);
  localparam logic [32:0] c_limit = 33'(CAPACITY_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        chan_q, chan_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] ram_rdata_q;
  logic [31:0] mem [CAPACITY_WORDS];

  logic            grant;
  logic            req_valid;
  logic            req_write;
  logic            req_err;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [c_aw-1:0] ram_idx;
  logic            accept;
  logic            ram_we;
  logic            resp_ready;
  logic            in_resp;

  // A lone requester wins outright; otherwise the channel not served last.
  always_comb begin
    grant = (ch0.hart_to_memory_controller_valid ^ ch1.hart_to_memory_controller_valid)
            ? ch1.hart_to_memory_controller_valid : ~last_grant_q;
    req_valid = grant ? ch1.hart_to_memory_controller_valid      : ch0.hart_to_memory_controller_valid;
    req_write = grant ? ch1.hart_to_memory_controller_write      : ch0.hart_to_memory_controller_write;
    req_addr  = grant ? ch1.hart_to_memory_controller_address    : ch0.hart_to_memory_controller_address;
    req_wdata = grant ? ch1.hart_to_memory_controller_write_data : ch0.hart_to_memory_controller_write_data;
    req_err   = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= c_limit);
    ram_idx   = req_addr[c_aw+1:2];
    accept    = (state_q == IDLE) && req_valid;
    ram_we    = accept && req_write && !req_err;
    resp_ready = chan_q ? ch1.memory_controller_to_hart_ready : ch0.memory_controller_to_hart_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    wr_d         = wr_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          chan_d       = grant;
          wr_d         = req_write;
          err_d        = req_err;
          last_grant_d = grant;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        resp_data_d = (!wr_q && !err_q) ? ram_rdata_q : 32'h0;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      chan_q       <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      resp_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chan_q       <= chan_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // RAM contents and its output register deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_idx] <= req_wdata;
    if (accept) ram_rdata_q <= mem[ram_idx];
  end

  assign in_resp = (state_q == RESPOND);

  assign ch0.hart_to_memory_controller_ready     = (state_q == IDLE) && !grant;
  assign ch1.hart_to_memory_controller_ready     = (state_q == IDLE) &&  grant;
  assign ch0.memory_controller_to_hart_valid     = in_resp && !chan_q;
  assign ch1.memory_controller_to_hart_valid     = in_resp &&  chan_q;
  assign ch0.memory_controller_to_hart_error     = in_resp && !chan_q && err_q;
  assign ch1.memory_controller_to_hart_error     = in_resp &&  chan_q && err_q;
  assign ch0.memory_controller_to_hart_read_data = (in_resp && !chan_q) ? resp_data_q : 32'h0;
  assign ch1.memory_controller_to_hart_read_data = (in_resp &&  chan_q) ? resp_data_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_memory_controller.sv
// ============================================================================
// tb_memory_controller
// Self-checking bench: directed scenarios plus randomized traffic vs a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_controller;

  localparam int c_cap = 4096;

  logic clock;
  logic clear;
  int   tests_run;
  int   tests_failed;

  memory_controller_if ch0_if ();
  memory_controller_if ch1_if ();

  memory_controller #(.CAPACITY_WORDS(c_cap)) dut (
    .clock (clock),
    .clear (clear),
    .ch0   (ch0_if),
    .ch1   (ch1_if)
  );

  logic [1:0]  w_rdy, w_rv, w_re;
  logic [31:0] w_rd0, w_rd1;
  assign w_rdy = {ch1_if.hart_to_memory_controller_ready, ch0_if.hart_to_memory_controller_ready};
  assign w_rv  = {ch1_if.memory_controller_to_hart_valid, ch0_if.memory_controller_to_hart_valid};
  assign w_re  = {ch1_if.memory_controller_to_hart_error, ch0_if.memory_controller_to_hart_error};
  assign w_rd0 = ch0_if.memory_controller_to_hart_read_data;
  assign w_rd1 = ch1_if.memory_controller_to_hart_read_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: word-indexed sparse memory plus the last served channel.
  logic [31:0] mdl_mem [int unsigned];
  int          mdl_last;

  task automatic model_txn(input logic [1:0] mask, input logic [31:0] a0, a1,
                           input logic w0, w1, input logic [31:0] d0, d1,
                           output int eg, output logic eerr, output logic [31:0] edata,
                           output logic known);
    logic [31:0] a, d;
    logic        w;
    if (mask == 2'b01)      eg = 0;
    else if (mask == 2'b10) eg = 1;
    else                    eg = 1 - mdl_last;
    mdl_last = eg;
    a = (eg == 1) ? a1 : a0;
    w = (eg == 1) ? w1 : w0;
    d = (eg == 1) ? d1 : d0;
    eerr  = (a % 4 != 0) || ({32'h0, a} >= 64'(4 * c_cap));
    edata = 32'h0;
    known = 1'b1;
    if (w) begin
      if (!eerr) mdl_mem[a / 4] = d;
    end else if (!eerr) begin
      known = mdl_mem.exists(a / 4);
      if (known) edata = mdl_mem[a / 4];
    end
  endtask

  task automatic drop_reqs();
    ch0_if.hart_to_memory_controller_valid = 1'b0;
    ch1_if.hart_to_memory_controller_valid = 1'b0;
  endtask

  // Drives one arbitration round and reports what the DUT did.
  task automatic run_txn(input logic [1:0] mask, input logic [31:0] a0, a1,
                         input logic w0, w1, input logic [31:0] d0, d1, input int bp,
                         output int g, output logic err, output logic [31:0] data,
                         output int lat, output logic hold_ok);
    int   waits;
    logic rv;
    g = -1; err = 1'b0; data = 32'h0; lat = 0; hold_ok = 1'b1; waits = 0; rv = 1'b0;
    @(negedge clock);
    ch0_if.hart_to_memory_controller_valid      = mask[0];
    ch0_if.hart_to_memory_controller_address    = a0;
    ch0_if.hart_to_memory_controller_write      = w0;
    ch0_if.hart_to_memory_controller_write_data = d0;
    ch1_if.hart_to_memory_controller_valid      = mask[1];
    ch1_if.hart_to_memory_controller_address    = a1;
    ch1_if.hart_to_memory_controller_write      = w1;
    ch1_if.hart_to_memory_controller_write_data = d1;
    while (g < 0 && waits < 10) begin
      #1;
      if (mask[0] && w_rdy[0])      g = 0;
      else if (mask[1] && w_rdy[1]) g = 1;
      if (g < 0) begin
        @(negedge clock);
        waits++;
      end
    end
    if (g < 0) begin
      drop_reqs();
      return;
    end
    @(posedge clock);
    #1;
    drop_reqs();
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      rv = w_rv[g];
      if (rv) break;
      if (w_rdy != 2'b00 || w_rv != 2'b00) hold_ok = 1'b0;
    end
    if (!rv) begin
      lat = -1;
      return;
    end
    err  = w_re[g];
    data = (g == 1) ? w_rd1 : w_rd0;
    if (w_rdy != 2'b00 || w_rv[1-g] || w_re[1-g] || ((g == 1) ? w_rd0 : w_rd1) != 32'h0)
      hold_ok = 1'b0;
    repeat (bp) begin
      @(negedge clock);
      if (!w_rv[g] || w_re[g] !== err || ((g == 1) ? w_rd1 : w_rd0) !== data || w_rdy != 2'b00)
        hold_ok = 1'b0;
    end
    if (g == 1) ch1_if.memory_controller_to_hart_ready = 1'b1;
    else        ch0_if.memory_controller_to_hart_ready = 1'b1;
    @(posedge clock);
    #1;
    ch0_if.memory_controller_to_hart_ready = 1'b0;
    ch1_if.memory_controller_to_hart_ready = 1'b0;
    if (w_rv != 2'b00 || w_rdy == 2'b00) hold_ok = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    drop_reqs();
    ch0_if.memory_controller_to_hart_ready = 1'b0;
    ch1_if.memory_controller_to_hart_ready = 1'b0;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    mdl_last = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++; if (w_rdy !== 2'b01) begin tests_failed++; $display("FAIL reset_ready: got %b want 01", w_rdy); end
    tests_run++; if (w_rv !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b want 00", w_rv); end
    tests_run++; if (w_re !== 2'b00) begin tests_failed++; $display("FAIL reset_error: got %b want 00", w_re); end
    tests_run++; if ((w_rd0 | w_rd1) !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h/%h want 0", w_rd0, w_rd1); end
  endtask

  task automatic test_write_read();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata;
    model_txn(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (g !== 0) begin tests_failed++; $display("FAIL wr_grant: got %0d want 0", g); end
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL wr_latency: got %0d want 2", lat); end
    tests_run++; if (err !== 1'b0 || data !== 32'h0) begin tests_failed++; $display("FAIL wr_resp: got err %b data %h want 0/0", err, data); end
    model_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL rd_latency: got %0d want 2", lat); end
    tests_run++; if (data !== 32'hDEADBEEF || err !== 1'b0) begin tests_failed++; $display("FAIL rd_data: got %h err %b want deadbeef/0", data, err); end
    tests_run++; if (hold !== 1'b1) begin tests_failed++; $display("FAIL rd_hold: got %b want 1", hold); end
  endtask

  task automatic test_arbitration();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      model_txn(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
      run_txn(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
      tests_run++; if (g !== (i % 2)) begin tests_failed++; $display("FAIL arb_grant[%0d]: got %0d want %0d", i, g, i % 2); end
      tests_run++; if (hold !== 1'b1) begin tests_failed++; $display("FAIL arb_isolation[%0d]: got %b want 1", i, hold); end
      if (known) begin
        tests_run++; if (data !== edata) begin tests_failed++; $display("FAIL arb_data[%0d]: got %h want %h", i, data, edata); end
      end
    end
  endtask

  task automatic test_unaligned();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata;
    model_txn(2'b10, 32'h0, 32'h102, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b10, 32'h0, 32'h102, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (g !== 1) begin tests_failed++; $display("FAIL unal_grant: got %0d want 1", g); end
    tests_run++; if (err !== 1'b1 || data !== 32'h0) begin tests_failed++; $display("FAIL unal_resp: got err %b data %h want 1/0", err, data); end
    model_txn(2'b10, 32'h0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b10, 32'h0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL unal_after: got %h want deadbeef", data); end
  endtask

  task automatic test_out_of_range();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata, prior;
    prior = $urandom;
    model_txn(2'b01, 32'h0, 32'h0, 1'b1, 1'b0, prior, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h0, 32'h0, 1'b1, 1'b0, prior, 32'h0, 0, g, err, data, lat, hold);
    model_txn(2'b01, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h12345678, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h4000, 32'h0, 1'b1, 1'b0, 32'h12345678, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (err !== 1'b1 || data !== 32'h0) begin tests_failed++; $display("FAIL oor_resp: got err %b data %h want 1/0", err, data); end
    model_txn(2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (data !== prior || err !== 1'b0) begin tests_failed++; $display("FAIL oor_alias: got %h err %b want %h/0", data, err, prior); end
    model_txn(2'b10, 32'h0, 32'h3FFC, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D, eg, eerr, edata, known);
    run_txn(2'b10, 32'h0, 32'h3FFC, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 0, g, err, data, lat, hold);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL top_word_err: got %b want 0", err); end
    model_txn(2'b10, 32'h0, 32'h3FFC, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b10, 32'h0, 32'h3FFC, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (data !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL top_word_data: got %h want cafef00d", data); end
  endtask

  task automatic test_backpressure();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata;
    model_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4, g, err, data, lat, hold);
    tests_run++; if (data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL bp_data: got %h want deadbeef", data); end
    tests_run++; if (hold !== 1'b1) begin tests_failed++; $display("FAIL bp_hold: got %b want 1", hold); end
  endtask

  task automatic test_reset_mid();
    int g, eg, lat; logic err, eerr, hold, known; logic [31:0] data, edata;
    @(negedge clock);
    ch0_if.hart_to_memory_controller_valid   = 1'b1;
    ch0_if.hart_to_memory_controller_address = 32'h100;
    ch0_if.hart_to_memory_controller_write   = 1'b0;
    @(posedge clock);
    #1;
    drop_reqs();
    repeat (2) @(negedge clock);
    tests_run++; if (w_rv !== 2'b01) begin tests_failed++; $display("FAIL mid_pre_valid: got %b want 01", w_rv); end
    clear = 1'b1;
    @(posedge clock);
    #1;
    tests_run++; if (w_rv !== 2'b00 || w_rdy !== 2'b01) begin tests_failed++; $display("FAIL mid_reset: got valid %b ready %b want 00/01", w_rv, w_rdy); end
    @(negedge clock);
    clear = 1'b0;
    mdl_last = 1;
    model_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, eg, eerr, edata, known);
    run_txn(2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, g, err, data, lat, hold);
    tests_run++; if (data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL mid_persist: got %h want deadbeef", data); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = 32'h100 + 4 * $urandom_range(0, 15);
    case ($urandom_range(0, 9))
      0:       return base + $urandom_range(1, 3);
      1:       return 32'h4000 + 4 * $urandom_range(0, 15);
      2:       return $urandom | 32'h8000_0000;
      3:       return 32'h3FFC;
      default: return base;
    endcase
  endfunction

  task automatic test_random();
    int g, eg, lat, bp; logic err, eerr, hold, known, w0, w1; logic [1:0] mask;
    logic [31:0] data, edata, a0, a1, d0, d1;
    for (int i = 0; i < 60; i++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = rand_addr(); a1 = rand_addr();
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      d0 = $urandom; d1 = $urandom;
      bp = $urandom_range(0, 3);
      model_txn(mask, a0, a1, w0, w1, d0, d1, eg, eerr, edata, known);
      run_txn(mask, a0, a1, w0, w1, d0, d1, bp, g, err, data, lat, hold);
      tests_run++; if (g !== eg) begin tests_failed++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", i, g, eg); end
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL rnd_latency[%0d]: got %0d want 2", i, lat); end
      tests_run++; if (err !== eerr) begin tests_failed++; $display("FAIL rnd_error[%0d]: got %b want %b", i, err, eerr); end
      tests_run++; if (hold !== 1'b1) begin tests_failed++; $display("FAIL rnd_handshake[%0d]: got %b want 1", i, hold); end
      if (known) begin
        tests_run++; if (data !== edata) begin tests_failed++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data, edata); end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mdl_last     = 1;
    clear        = 1'b1;
    ch0_if.hart_to_memory_controller_valid      = 1'b0;
    ch0_if.hart_to_memory_controller_address    = 32'h0;
    ch0_if.hart_to_memory_controller_write      = 1'b0;
    ch0_if.hart_to_memory_controller_write_data = 32'h0;
    ch0_if.memory_controller_to_hart_ready      = 1'b0;
    ch1_if.hart_to_memory_controller_valid      = 1'b0;
    ch1_if.hart_to_memory_controller_address    = 32'h0;
    ch1_if.hart_to_memory_controller_write      = 1'b0;
    ch1_if.hart_to_memory_controller_write_data = 32'h0;
    ch1_if.memory_controller_to_hart_ready      = 1'b0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_unaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
